// File: rtl/fpu_dispatch_seq_pkg.sv
// FPU dispatch shared types: op codes, unit encoding and op-to-unit decode.
package FPU_pkg;

    typedef logic [1:0] unit_t;

    localparam unit_t FPU_UNIT_ADD = 2'd0;
    localparam unit_t FPU_UNIT_MUL = 2'd1;
    localparam unit_t FPU_UNIT_CMP = 2'd2;
    localparam int    FPU_N_UNITS  = 3;

    localparam logic [4:0] FPU_OP_ADD = 5'd0;
    localparam logic [4:0] FPU_OP_SUB = 5'd1;
    localparam logic [4:0] FPU_OP_MUL = 5'd2;
    localparam logic [4:0] FPU_OP_SEQ = 5'd3;
    localparam logic [4:0] FPU_OP_SLT = 5'd4;
    localparam logic [4:0] FPU_OP_SLE = 5'd5;
    localparam logic [4:0] FPU_OP_MIN = 5'd6;
    localparam logic [4:0] FPU_OP_MAX = 5'd7;

    typedef struct packed {
        unit_t unit;
        logic  legal;
    } unit_sel_t;

    function automatic unit_sel_t fpu_unit_sel(input logic [4:0] op);
        unit_sel_t s;
        s.unit  = FPU_UNIT_ADD;
        s.legal = 1'b1;
        case (op)
            FPU_OP_ADD, FPU_OP_SUB: s.unit = FPU_UNIT_ADD;
            FPU_OP_MUL:             s.unit = FPU_UNIT_MUL;
            FPU_OP_SEQ, FPU_OP_SLT, FPU_OP_SLE,
            FPU_OP_MIN, FPU_OP_MAX: s.unit = FPU_UNIT_CMP;
            default:                s.legal = 1'b0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/fpu_dispatch_seq_tag_fifo.sv
// Order FIFO holding the unit tag of each accepted operation, oldest at head.
module fpu_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] data_in,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    // A full FIFO refuses a push even when a pop frees a slot this cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= data_in;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fpu_dispatch_seq.sv
// Issues FPU ops to ADD/MUL/CMP units and retires their results in acceptance order.
module fpu_dispatch_seq
    import FPU_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        valid_in,
    output logic        ready_out,
    input  logic [4:0]  op,
    output logic [2:0]  u_valid_out,
    input  logic [2:0]  u_ready_in,
    input  logic [2:0]  u_valid_in,
    output logic [2:0]  u_ready_out,
    input  logic [95:0] u_result,
    input  logic [14:0] u_flags,
    output logic        valid_out,
    input  logic        ready_in,
    output logic [31:0] result,
    output logic [4:0]  flags,
    output logic        busy
);

    localparam int CW = $clog2(DEPTH) + 1;

    unit_sel_t     sel;
    unit_t         h;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic [3:0]    uri;
    logic [3:0]    uvi;
    logic [3:0]    sel_oh;
    logic [3:0]    head_oh;
    logic          issue_ok;
    logic          accept;
    logic          pop;

    assign sel     = fpu_unit_sel(op);
    assign uri     = {1'b0, u_ready_in};
    assign uvi     = {1'b0, u_valid_in};
    assign sel_oh  = 4'b0001 << sel.unit;
    assign head_oh = 4'b0001 << h;

    assign issue_ok    = valid_in && sel.legal && !full && !flush && reset;
    assign ready_out   = sel.legal && uri[sel.unit] && !full && !flush && reset;
    assign u_valid_out = issue_ok ? sel_oh[2:0] : 3'b000;
    assign accept      = valid_in && ready_out;

    // Only the oldest unit may hand back a result; younger completions stall.
    assign valid_out   = !empty && uvi[h] && !flush && reset;
    assign u_ready_out = (ready_in && !empty && !flush && reset) ? head_oh[2:0] : 3'b000;
    assign pop         = valid_out && ready_in;
    assign busy        = (count != '0);

    always_comb begin
        result = 32'd0;
        flags  = 5'd0;
        if (valid_out) begin
            case (h)
                FPU_UNIT_ADD: begin result = u_result[31:0];  flags = u_flags[4:0];   end
                FPU_UNIT_MUL: begin result = u_result[63:32]; flags = u_flags[9:5];   end
                FPU_UNIT_CMP: begin result = u_result[95:64]; flags = u_flags[14:10]; end
                default:      begin result = 32'd0;           flags = 5'd0;           end
            endcase
        end
    end

    fpu_tag_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(unit_t))
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (accept),
        .pop     (pop),
        .flush   (flush),
        .data_in (sel.unit),
        .full    (full),
        .empty   (empty),
        .head    (h),
        .count   (count)
    );

endmodule

// File: tb/tb_fpu_dispatch_seq.sv
// Directed bench for fpu_dispatch_seq: issue, in-order retire, full, flush, reset, wrap.
module tb_fpu_dispatch_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        valid_in;
    logic        ready_out;
    logic [4:0]  op;
    logic [2:0]  u_valid_out;
    logic [2:0]  u_ready_in;
    logic [2:0]  u_valid_in;
    logic [2:0]  u_ready_out;
    logic [95:0] u_result;
    logic [14:0] u_flags;
    logic        valid_out;
    logic        ready_in;
    logic [31:0] result;
    logic [4:0]  flags;
    logic        busy;

    int errs   = 0;
    int checks = 0;

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_MUL = 5'd2;
    localparam logic [4:0] OP_SEQ = 5'd3;
    localparam logic [4:0] OP_BAD = 5'd31;

    always #5 clk = ~clk;

    fpu_dispatch_seq #(.DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .valid_in    (valid_in),
        .ready_out   (ready_out),
        .op          (op),
        .u_valid_out (u_valid_out),
        .u_ready_in  (u_ready_in),
        .u_valid_in  (u_valid_in),
        .u_ready_out (u_ready_out),
        .u_result    (u_result),
        .u_flags     (u_flags),
        .valid_out   (valid_out),
        .ready_in    (ready_in),
        .result      (result),
        .flags       (flags),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        flush      = 1'b0;
        valid_in   = 1'b0;
        op         = OP_ADD;
        u_ready_in = 3'b111;
        u_valid_in = 3'b000;
        u_result   = '0;
        u_flags    = '0;
        ready_in   = 1'b0;
    endtask

    function automatic logic [4:0] op_of(input int u);
        case (u)
            0:       return OP_ADD;
            1:       return OP_MUL;
            default: return OP_SEQ;
        endcase
    endfunction

    initial begin
        reset = 1'b0;
        idle_inputs();
        valid_in = 1'b1;
        tick();
        tick();
        settle();
        chk("rst_ready_out", 32'(ready_out), 0);
        chk("rst_u_valid_out", 32'(u_valid_out), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid_out", 32'(valid_out), 0);
        chk("rst_result", result, 0);

        reset = 1'b1;
        idle_inputs();
        tick();

        // Illegal op and a busy target unit both block issue
        valid_in = 1'b1;
        op = OP_BAD;
        settle();
        chk("bad_ready_out", 32'(ready_out), 0);
        chk("bad_u_valid_out", 32'(u_valid_out), 0);
        op = OP_MUL;
        u_ready_in = 3'b101;
        settle();
        chk("mulbusy_ready_out", 32'(ready_out), 0);
        u_ready_in = 3'b111;

        // SEQ goes to CMP and retires the following cycle
        op = OP_SEQ;
        settle();
        chk("seq_ready_out", 32'(ready_out), 1);
        chk("seq_u_valid_out", 32'(u_valid_out), 32'b100);
        tick();
        valid_in = 1'b0;
        chk("seq_busy", 32'(busy), 1);
        u_valid_in = 3'b100;
        u_result[95:64] = 32'h1;
        ready_in = 1'b1;
        settle();
        chk("seq_valid_out", 32'(valid_out), 1);
        chk("seq_result", result, 32'h1);
        chk("seq_flags", 32'(flags), 0);
        chk("seq_u_ready_out", 32'(u_ready_out), 32'b100);
        tick();
        idle_inputs();
        settle();
        chk("seq_busy_after", 32'(busy), 0);

        // MUL then CMP; CMP finishing first must wait for MUL
        valid_in = 1'b1;
        op = OP_MUL;
        settle();
        chk("mc_u_valid_mul", 32'(u_valid_out), 32'b010);
        tick();
        op = OP_SEQ;
        settle();
        chk("mc_u_valid_cmp", 32'(u_valid_out), 32'b100);
        tick();
        valid_in = 1'b0;
        u_valid_in = 3'b100;
        u_result[95:64] = 32'h1;
        settle();
        chk("mc_hold_valid_out", 32'(valid_out), 0);
        chk("mc_hold_u_ready_out", 32'(u_ready_out), 0);
        chk("mc_hold_result", result, 0);
        ready_in = 1'b1;
        settle();
        chk("mc_head_only_ready", 32'(u_ready_out), 32'b010);
        chk("mc_still_invalid", 32'(valid_out), 0);
        tick();
        u_valid_in = 3'b110;
        u_result[63:32] = 32'h3f80_0000;
        u_flags[9:5] = 5'b00001;
        settle();
        chk("mc_mul_valid", 32'(valid_out), 1);
        chk("mc_mul_result", result, 32'h3f80_0000);
        chk("mc_mul_flags", 32'(flags), 32'b00001);
        tick();
        u_valid_in = 3'b100;
        settle();
        chk("mc_cmp_valid", 32'(valid_out), 1);
        chk("mc_cmp_result", result, 32'h1);
        chk("mc_cmp_flags", 32'(flags), 0);
        tick();
        idle_inputs();
        settle();
        chk("mc_busy_after", 32'(busy), 0);

        // Fill to DEPTH, then a same-cycle pop must not let the 5th in
        valid_in = 1'b1;
        op = OP_ADD;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk($sformatf("full_acc%0d", i), 32'(ready_out), 1);
            tick();
        end
        settle();
        chk("full_refuse", 32'(ready_out), 0);
        chk("full_u_valid_out", 32'(u_valid_out), 0);
        ready_in = 1'b1;
        u_valid_in = 3'b001;
        u_result[31:0] = 32'ha0;
        settle();
        chk("full_pop_valid", 32'(valid_out), 1);
        chk("full_refuse_on_pop", 32'(ready_out), 0);
        tick();
        chk("full_accept_next", 32'(ready_out), 1);
        tick();
        valid_in = 1'b0;
        tick();
        tick();
        chk("full_busy_one_left", 32'(busy), 1);
        tick();
        chk("full_drained", 32'(busy), 0);
        idle_inputs();

        // Flush with three in flight
        for (int i = 0; i < 3; i++) begin
            valid_in = 1'b1;
            op = op_of(i);
            tick();
        end
        flush = 1'b1;
        valid_in = 1'b1;
        op = OP_ADD;
        u_valid_in = 3'b111;
        ready_in = 1'b1;
        settle();
        chk("fl_busy_before", 32'(busy), 1);
        chk("fl_valid_out", 32'(valid_out), 0);
        chk("fl_u_ready_out", 32'(u_ready_out), 0);
        chk("fl_ready_out", 32'(ready_out), 0);
        chk("fl_u_valid_out", 32'(u_valid_out), 0);
        tick();
        flush = 1'b0;
        valid_in = 1'b0;
        settle();
        chk("fl_busy_after", 32'(busy), 0);
        chk("fl_no_retire", 32'(valid_out), 0);
        chk("fl_no_u_ready", 32'(u_ready_out), 0);
        idle_inputs();

        // Reset mid-operation with two in flight
        for (int i = 0; i < 2; i++) begin
            valid_in = 1'b1;
            op = op_of(i);
            tick();
        end
        reset = 1'b0;
        valid_in = 1'b1;
        u_valid_in = 3'b111;
        ready_in = 1'b1;
        settle();
        chk("mr_ready_out", 32'(ready_out), 0);
        chk("mr_u_valid_out", 32'(u_valid_out), 0);
        chk("mr_valid_out", 32'(valid_out), 0);
        chk("mr_u_ready_out", 32'(u_ready_out), 0);
        tick();
        reset = 1'b1;
        valid_in = 1'b0;
        settle();
        chk("mr_busy_after", 32'(busy), 0);
        chk("mr_no_retire", 32'(valid_out), 0);
        idle_inputs();

        // Ten pushes with nine overlapping pops wrap both pointers
        ready_in = 1'b1;
        u_valid_in = 3'b111;
        valid_in = 1'b1;
        op = op_of(0);
        tick();
        for (int i = 1; i <= 9; i++) begin
            for (int k = 0; k < 3; k++)
                u_result[k*32 +: 32] = 32'(k * 32'h1000 + (i - 1));
            op = op_of(i % 3);
            settle();
            chk($sformatf("wrap_ready%0d", i), 32'(ready_out), 1);
            chk($sformatf("wrap_res%0d", i), result,
                32'(((i - 1) % 3) * 32'h1000 + (i - 1)));
            tick();
        end
        valid_in = 1'b0;
        for (int k = 0; k < 3; k++)
            u_result[k*32 +: 32] = 32'(k * 32'h1000 + 9);
        settle();
        chk("wrap_last", result, 32'h9);
        tick();
        chk("wrap_busy_after", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
